// File: rtl/clkmgr_byp_responder.sv
// Clock-manager side of the life-cycle clock-bypass handshake: synchronizes the
// lc_tx_t bypass request, drives the external clock mux and returns the lc_tx_t ack.
module clkmgr_byp_responder #(
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned StableCycles  = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] lc_clk_byp_req_i,
    input  logic       ext_switch_ack_i,
    output logic       ext_switch_req_o,
    output logic [3:0] lc_clk_byp_ack_o,
    output logic       timeout_o,
    output logic       invalid_enc_o
);

    localparam logic [3:0] LC_ON  = 4'b1010;
    localparam logic [3:0] LC_OFF = 4'b0101;

    localparam int unsigned SW = $clog2(StableCycles + 1);
    localparam int unsigned TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [SW-1:0] STABLE_MAX   = SW'(StableCycles);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        SWITCHING,
        ACKED,
        RELEASING,
        FAILED
    } state_t;

    logic [3:0]    sync_q [SyncStages];
    logic [3:0]    synced;
    logic [3:0]    prev_q;
    logic [SW-1:0] stable_q;
    logic          req_on;
    logic          req_off;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] tcnt_q;
    logic [TW-1:0] tcnt_d;
    logic          timed_out;
    logic          switch_d;
    logic [3:0]    ack_d;
    logic          timeout_d;

    // Each bit passes through its own flop chain; the vector form is bitwise identical.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < SyncStages; i++) begin
                sync_q[i] <= LC_OFF;
            end
        end else begin
            sync_q[0] <= lc_clk_byp_req_i;
            for (int unsigned i = 1; i < SyncStages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced = sync_q[SyncStages-1];

    // stable_q counts consecutive cycles prev_q has held, saturating at StableCycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q        <= LC_OFF;
            stable_q      <= '0;
            invalid_enc_o <= 1'b0;
        end else begin
            prev_q        <= synced;
            invalid_enc_o <= (synced != LC_ON) && (synced != LC_OFF);
            if (synced != prev_q) begin
                stable_q <= SW'(1);
            end else if (stable_q != STABLE_MAX) begin
                stable_q <= stable_q + SW'(1);
            end
        end
    end

    assign req_on    = (stable_q == STABLE_MAX) && (prev_q == LC_ON);
    assign req_off   = (stable_q == STABLE_MAX) && (prev_q != LC_ON);
    assign timed_out = (tcnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            tcnt_q           <= '0;
            ext_switch_req_o <= 1'b0;
            lc_clk_byp_ack_o <= LC_OFF;
            timeout_o        <= 1'b0;
        end else begin
            state_q          <= state_d;
            tcnt_q           <= tcnt_d;
            ext_switch_req_o <= switch_d;
            lc_clk_byp_ack_o <= ack_d;
            timeout_o        <= timeout_d;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_on) state_d = SWITCHING;
            end
            SWITCHING: begin
                if (ext_switch_ack_i)  state_d = ACKED;
                else if (req_off)      state_d = RELEASING;
                else if (timed_out)    state_d = FAILED;
            end
            ACKED: begin
                if (req_off) state_d = RELEASING;
            end
            RELEASING: begin
                if (!ext_switch_ack_i) state_d = IDLE;
                else if (timed_out)    state_d = FAILED;
            end
            FAILED: begin
                if (req_off && !ext_switch_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        tcnt_d = '0;
        if ((state_d == state_q) && ((state_q == SWITCHING) || (state_q == RELEASING))) begin
            tcnt_d = tcnt_q + TW'(1);
        end

        switch_d  = (state_d == SWITCHING) || (state_d == ACKED);
        ack_d     = (state_d == ACKED) ? LC_ON : LC_OFF;
        timeout_d = (state_d == FAILED) && (state_q != FAILED);
    end

endmodule

// File: tb/tb_clkmgr_byp_responder.sv
// Directed and randomized bench for clkmgr_byp_responder, checked every cycle against
// a window-based reference model of the bypass handshake.
module tb_clkmgr_byp_responder;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int TMO    = 1024;
    localparam logic [3:0] ON  = 4'b1010;
    localparam logic [3:0] OFF = 4'b0101;
    localparam int HIST = 16384;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = OFF;
    logic       ack_in = 1'b0;
    logic       ext_switch_req_o;
    logic [3:0] lc_clk_byp_ack_o;
    logic       timeout_o;
    logic       invalid_enc_o;

    always #5 clk = ~clk;

    clkmgr_byp_responder #(
        .SyncStages   (SYNC),
        .StableCycles (STABLE),
        .TimeoutCycles(TMO)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .lc_clk_byp_req_i (req),
        .ext_switch_ack_i (ack_in),
        .ext_switch_req_o (ext_switch_req_o),
        .lc_clk_byp_ack_o (lc_clk_byp_ack_o),
        .timeout_o        (timeout_o),
        .invalid_enc_o    (invalid_enc_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int r_base = 0;
    logic [3:0] in_hist [HIST];

    typedef enum {M_IDLE, M_SW, M_ACK, M_REL, M_FAIL} mstate_t;
    mstate_t ms = M_IDLE;
    mstate_t ms_prev = M_IDLE;
    int enter = 0;

    int mux_delay = 3;
    int mux_drop = 0;
    bit mux_never = 0;
    bit mux_glitch = 0;
    int hi_n = 0;
    int lo_n = 0;
    int sw_seen = 0;
    int inv_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Value seen at the synchronizer output during cycle k (valid for k >= r_base).
    function automatic logic [3:0] synced_at(input int k);
        if (k - SYNC >= r_base) return in_hist[(k - SYNC) % HIST];
        return OFF;
    endfunction

    function automatic bit win_on(input int c);
        if (c - STABLE < r_base) return 1'b0;
        for (int k = c - STABLE; k < c; k++)
            if (synced_at(k) !== ON) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit win_off(input int c);
        logic [3:0] last;
        if (c - STABLE < r_base) return 1'b0;
        last = synced_at(c - 1);
        if (last === ON) return 1'b0;
        for (int k = c - STABLE; k < c; k++)
            if (synced_at(k) !== last) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        mstate_t nx;
        bit on, off, tmo;
        logic [3:0] sv;
        in_hist[cyc % HIST] = req;
        on  = win_on(cyc);
        off = win_off(cyc);
        tmo = ((cyc - enter) == TMO - 1);
        nx = ms;
        case (ms)
            M_IDLE:  if (on) nx = M_SW;
            M_SW:    if (ack_in) nx = M_ACK; else if (off) nx = M_REL; else if (tmo) nx = M_FAIL;
            M_ACK:   if (off) nx = M_REL;
            M_REL:   if (!ack_in) nx = M_IDLE; else if (tmo) nx = M_FAIL;
            M_FAIL:  if (off && !ack_in) nx = M_IDLE;
            default: nx = M_IDLE;
        endcase
        @(posedge clk);
        #1;
        cyc++;
        ms_prev = ms;
        if (nx != ms) enter = cyc;
        ms = nx;
        sv = synced_at(cyc - 1);
        chk("switch_req", ext_switch_req_o, (ms == M_SW) || (ms == M_ACK));
        chk("byp_ack", lc_clk_byp_ack_o, (ms == M_ACK) ? ON : OFF);
        chk("timeout", timeout_o, (ms == M_FAIL) && (ms_prev != M_FAIL));
        chk("invalid_enc", invalid_enc_o, (cyc - 1 >= r_base) && (sv !== ON) && (sv !== OFF));
        if (ext_switch_req_o === 1'b1) sw_seen++;
        if (invalid_enc_o === 1'b1) inv_seen++;
        // behavioural clock mux answering the switch request
        if (ext_switch_req_o === 1'b1) begin
            hi_n++;
            lo_n = 0;
            if (!mux_never && hi_n > mux_delay) ack_in = 1'b1;
        end else begin
            hi_n = 0;
            lo_n++;
            if (lo_n > mux_drop) ack_in = 1'b0;
        end
        if (mux_glitch && ack_in && $urandom_range(0, 15) == 0) ack_in = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    function automatic bit cond(input int which);
        case (which)
            0: return ext_switch_req_o === 1'b1;
            1: return lc_clk_byp_ack_o === ON;
            2: return timeout_o === 1'b1;
            default: return ext_switch_req_o === 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int budget, output int at);
        bit found;
        found = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (cond(which)) begin
                found = 1'b1;
                at = cyc;
            end
        end
        chk({tag, "_seen"}, found, 1'b1);
    endtask

    task automatic assert_reset(input string tag);
        #2;
        rst = 1'b1;
        ack_in = 1'b0;
        hi_n = 0;
        lo_n = 0;
        #1;
        chk({tag, "_switch_req"}, ext_switch_req_o, 1'b0);
        chk({tag, "_byp_ack"}, lc_clk_byp_ack_o, OFF);
        chk({tag, "_timeout"}, timeout_o, 1'b0);
        chk({tag, "_invalid"}, invalid_enc_o, 1'b0);
    endtask

    task automatic release_reset();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        rst = 1'b0;
        r_base = cyc;
        ms = M_IDLE;
        ms_prev = M_IDLE;
        enter = cyc;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=stuck expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, at, a2, tt, s0, i0;
        assert_reset("rst_init");
        release_reset();
        run(10);

        // 1: basic handshake and latency
        req = ON;
        c0 = cyc;
        wait_for("s1_rise", 0, 20, at);
        chk("s1_latency", at - c0, SYNC + STABLE + 1);
        wait_for("s1_ack", 1, 20, a2);
        chk("s1_ack_delay", a2 - at, mux_delay + 1);
        run(5);

        // 2: release, then a second identical episode
        req = OFF;
        c0 = cyc;
        wait_for("s2_fall", 3, 20, tt);
        chk("s2_release", tt - c0, SYNC + STABLE + 1);
        run(20);
        req = ON;
        c0 = cyc;
        wait_for("s2_rise2", 0, 20, at);
        chk("s2_latency2", at - c0, SYNC + STABLE + 1);
        wait_for("s2_ack2", 1, 20, a2);
        chk("s2_ack_delay2", a2 - at, mux_delay + 1);
        req = OFF;
        run(20);

        // 3: mux never answers
        mux_never = 1;
        req = ON;
        wait_for("s3_rise", 0, 20, at);
        wait_for("s3_tmo", 2, TMO + 50, tt);
        chk("s3_timeout_dist", tt - at, TMO);
        run(3);
        req = OFF;
        run(15);
        chk("s3_back_idle", ext_switch_req_o, 1'b0);
        mux_never = 0;

        // 4: unstable and invalid requests never start a switch
        s0 = sw_seen;
        i0 = inv_seen;
        for (int i = 0; i < 10; i++) begin
            req = ON;  run(2);
            req = OFF; run(2);
        end
        req = 4'b1111; run(8);
        req = 4'b0000; run(8);
        req = OFF;     run(10);
        chk("s4_no_switch", sw_seen - s0, 0);
        chk("s4_invalid_seen", (inv_seen - i0) > 0, 1'b1);

        // 5: asynchronous reset in ACKED and in SWITCHING
        req = ON;
        wait_for("s5_ack", 1, 40, a2);
        run(2);
        assert_reset("s5_rst_acked");
        release_reset();
        c0 = r_base;
        wait_for("s5_rise", 0, 20, at);
        chk("s5_latency_acked", at - c0, SYNC + STABLE + 1);
        run(1);
        assert_reset("s5_rst_switching");
        release_reset();
        c0 = r_base;
        wait_for("s5_rise2", 0, 20, at);
        chk("s5_latency_sw", at - c0, SYNC + STABLE + 1);
        req = OFF;
        run(20);

        // 6: mux ack arrives on the last timeout cycle
        mux_delay = TMO - 1;
        req = ON;
        wait_for("s6_rise", 0, 20, at);
        wait_for("s6_ack", 1, TMO + 50, a2);
        chk("s6_ack_at", a2 - at, TMO);
        req = OFF;
        mux_delay = 3;
        run(20);

        // randomized episodes
        mux_glitch = 1;
        for (int e = 0; e < 80; e++) begin
            int pick;
            mux_delay = $urandom_range(0, 30);
            mux_drop  = $urandom_range(0, 6);
            mux_never = ($urandom_range(0, 9) == 0);
            pick = $urandom_range(0, 9);
            if (pick < 5)      req = ON;
            else if (pick < 8) req = OFF;
            else               req = 4'($urandom);
            run($urandom_range(1, 40));
        end
        mux_glitch = 0;
        mux_never = 0;
        req = OFF;
        run(40);
        chk("final_idle", ext_switch_req_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
